// File: rtl/pci_init_arb.sv
//------------------------------------------------------------------------------
// Module      : pci_init_arb
// Description : Round-robin initiator arbiter and transfer sequencer for the
//               PCI core master port. Optional re-issue of disconnected
//               transfers is enabled by defining PCI_INIT_ARB_RETRY_EN.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module pci_init_arb #(
    parameter int NREQ      = 4,
    parameter int MAX_RETRY = 7,
    parameter int TDLY      = 1
) (
    input  logic                 CLK,
    input  logic                 RST_N,
    input  logic [NREQ-1:0]      REQ,
    input  logic [32*NREQ-1:0]   REQ_ADDR,
    input  logic [NREQ-1:0]      REQ_WRDN,
    input  logic [4*NREQ-1:0]    REQ_LEN,
    output logic [NREQ-1:0]      GNT,
    output logic [NREQ-1:0]      DVLD,
    output logic [NREQ-1:0]      DONE,
    output logic                 ERR,
    output logic                 REQUEST,
    output logic                 COMPLETE,
    output logic                 M_WRDN,
    output logic [3:0]           M_CBE,
    output logic [31:0]          M_ADDR,
    input  logic                 M_DATA,
    input  logic                 M_DATA_VLD,
    input  logic                 M_ADDR_N,
    input  logic                 TIME_OUT
);

    localparam int          c_iw        = $clog2(NREQ);
    localparam logic [3:0]  c_max_retry = 4'(MAX_RETRY);
    localparam logic [31:0] c_tdly      = 32'(TDLY);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LATCH = 3'd1,
        S_REQ   = 3'd2,
        S_XFER  = 3'd3,
        S_FIN   = 3'd4
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;

    logic [c_iw-1:0]   r_ptr;
    logic [c_iw-1:0]   r_idx;
    logic [29:0]       r_addr;
    logic              r_wrdn;
    logic [4:0]        r_rem;
    logic [3:0]        r_retry;
    logic              r_md1;
    logic              r_md2;
    logic              r_seen;
    logic              r_to;
    logic              r_err;
    logic              r_over;

    logic [29:0]       w_addr_arr [NREQ];
    logic [4:0]        w_len_arr  [NREQ];
    logic [2*NREQ-1:0] w_addr_lo;
    logic [c_iw-1:0]   w_cand;
    logic [c_iw-1:0]   w_win;
    logic              w_found;
    logic              w_rise;
    logic              w_fall;
    logic              w_busy;
    logic              w_held;
    logic [NREQ-1:0]   w_oh;
    logic              w_unused;

    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
            assign w_addr_arr[gi]       = REQ_ADDR[32*gi+2 +: 30];
            assign w_len_arr[gi]        = (REQ_LEN[4*gi +: 4] == 4'd0) ? 5'd16
                                          : {1'b0, REQ_LEN[4*gi +: 4]};
            assign w_addr_lo[2*gi +: 2] = REQ_ADDR[32*gi +: 2];
        end
    endgenerate

    // Byte-lane address bits and the simulation delay have no effect on logic.
    assign w_unused = ^{w_addr_lo, c_tdly};

    // Search upward from the last winner so every requester gets a turn.
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        w_cand  = '0;
        for (int k = 1; k <= NREQ; k++) begin
            w_cand = c_iw'((int'(r_ptr) + k) % NREQ);
            if (!w_found && REQ[w_cand]) begin
                w_found = 1'b1;
                w_win   = w_cand;
            end
        end
    end

    assign w_rise = r_md1 & ~r_md2;
    assign w_fall = r_seen & r_md2 & ~r_md1;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_busy      = (r_state == S_REQ) || (r_state == S_XFER);
        w_held      = w_busy || (r_state == S_FIN);
        w_oh        = {{(NREQ-1){1'b0}}, 1'b1} << r_idx;
        GNT         = '0;
        DVLD        = '0;
        DONE        = '0;
        ERR         = 1'b0;
        REQUEST     = 1'b0;
        COMPLETE    = 1'b0;
        M_CBE       = 4'h0;
        M_ADDR      = 32'h0;

        case (r_state)
            S_IDLE:  if (|REQ) w_state_nxt = S_LATCH;
            S_LATCH: w_state_nxt = w_found ? S_REQ : S_IDLE;
            S_REQ:   w_state_nxt = S_XFER;
            S_XFER: begin
                if (w_fall) begin
                    if (r_rem == 5'd0) begin
                        w_state_nxt = S_FIN;
                    end else begin
`ifdef PCI_INIT_ARB_RETRY_EN
                        w_state_nxt = (r_retry < c_max_retry) ? S_REQ : S_FIN;
`else
                        w_state_nxt = S_FIN;
`endif
                    end
                end
            end
            S_FIN:   w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase

        if (w_held) begin
            GNT  = w_oh;
            DVLD = w_oh & {NREQ{M_DATA_VLD}};
        end
        if (r_state == S_FIN) begin
            DONE = w_oh;
            ERR  = r_err | r_over;
        end
        REQUEST = (r_state == S_REQ);
        // Two phases of lookahead, or forced early by a target timeout.
        COMPLETE = (w_busy && (r_rem <= 5'd2))
                   || ((r_state == S_XFER)
                       && (r_to || (TIME_OUT && (r_rem > 5'd2))));
        if (w_busy && !M_ADDR_N) begin
            M_CBE  = r_wrdn ? 4'h7 : 4'h6;
            M_ADDR = {r_addr, 2'b00};
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_ptr   <= c_iw'(NREQ - 1);
            r_idx   <= '0;
            r_addr  <= '0;
            r_wrdn  <= 1'b0;
            r_rem   <= '0;
            r_retry <= '0;
            r_md1   <= 1'b0;
            r_md2   <= 1'b0;
            r_seen  <= 1'b0;
            r_to    <= 1'b0;
            r_err   <= 1'b0;
            r_over  <= 1'b0;
        end else begin
            r_md1 <= M_DATA;
            r_md2 <= r_md1;
            case (r_state)
                S_LATCH: begin
                    if (w_found) begin
                        r_idx   <= w_win;
                        r_ptr   <= w_win;
                        r_addr  <= w_addr_arr[w_win];
                        r_wrdn  <= REQ_WRDN[w_win];
                        r_rem   <= w_len_arr[w_win];
                        r_retry <= '0;
                        r_seen  <= 1'b0;
                        r_to    <= 1'b0;
                        r_err   <= 1'b0;
                        r_over  <= 1'b0;
                    end
                end
                S_REQ: begin
                    if (w_rise) r_seen <= 1'b1;
                end
                S_XFER: begin
                    if (w_rise) r_seen <= 1'b1;
                    if (M_DATA_VLD) begin
                        if (r_rem != 5'd0) begin
                            r_rem  <= r_rem - 5'd1;
                            r_addr <= r_addr + 30'd1;
                        end else begin
                            r_over <= 1'b1;
                        end
                    end
                    if (TIME_OUT && (r_rem > 5'd2)) r_to <= 1'b1;
                    if (w_fall) begin
                        r_seen <= 1'b0;
                        r_to   <= 1'b0;
                        if (r_rem != 5'd0) begin
`ifdef PCI_INIT_ARB_RETRY_EN
                            if (r_retry < c_max_retry) r_retry <= r_retry + 4'd1;
                            else                       r_err   <= 1'b1;
`else
                            r_err <= 1'b1;
`endif
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign M_WRDN = r_wrdn;

endmodule

`default_nettype wire

// File: tb/tb_pci_init_arb.sv
//------------------------------------------------------------------------------
// Module      : tb_pci_init_arb
// Description : Self-checking bench for pci_init_arb with a DONE/ERR scoreboard.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_pci_init_arb;

    logic         CLK = 1'b0;
    logic         RST_N = 1'b0;
    logic [3:0]   REQ = '0;
    logic [127:0] REQ_ADDR = '0;
    logic [3:0]   REQ_WRDN = '0;
    logic [15:0]  REQ_LEN = '0;
    logic [3:0]   GNT, DVLD, DONE;
    logic         ERR, REQUEST, COMPLETE, M_WRDN;
    logic [3:0]   M_CBE;
    logic [31:0]  M_ADDR;
    logic         M_DATA = 1'b0, M_DATA_VLD = 1'b0, M_ADDR_N = 1'b1, TIME_OUT = 1'b0;

    pci_init_arb #(.NREQ(4), .MAX_RETRY(2), .TDLY(1)) dut (
        .CLK(CLK), .RST_N(RST_N), .REQ(REQ), .REQ_ADDR(REQ_ADDR),
        .REQ_WRDN(REQ_WRDN), .REQ_LEN(REQ_LEN), .GNT(GNT), .DVLD(DVLD),
        .DONE(DONE), .ERR(ERR), .REQUEST(REQUEST), .COMPLETE(COMPLETE),
        .M_WRDN(M_WRDN), .M_CBE(M_CBE), .M_ADDR(M_ADDR), .M_DATA(M_DATA),
        .M_DATA_VLD(M_DATA_VLD), .M_ADDR_N(M_ADDR_N), .TIME_OUT(TIME_OUT)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        int   idx;
        logic err;
    } exp_t;

    exp_t sb[$];
    int   n_total = 0;
    int   n_bad   = 0;

    // Scoreboard: every DONE pulse must match the oldest expected completion.
    always @(negedge CLK) begin
        exp_t e;
        if (RST_N) begin
            n_total++;
            if (!$onehot0(GNT)) begin
                n_bad++;
                $display("FAIL gnt_onehot: got GNT=%b required at most one bit", GNT);
            end
            if (|DONE) begin
                if (sb.size() == 0) begin
                    n_total++; n_bad++;
                    $display("FAIL unexpected_done: got DONE=%b required none", DONE);
                end else begin
                    e = sb.pop_front();
                    n_total += 2;
                    if (DONE !== 4'(1 << e.idx)) begin
                        n_bad++;
                        $display("FAIL done_idx: got DONE=%b required %b", DONE, 4'(1 << e.idx));
                    end
                    if (ERR !== e.err) begin
                        n_bad++;
                        $display("FAIL done_err: got ERR=%b required %b", ERR, e.err);
                    end
                end
            end else begin
                n_total++;
                if (ERR !== 1'b0) begin
                    n_bad++;
                    $display("FAIL err_no_done: got ERR=%b required 0", ERR);
                end
            end
        end
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic set_req(input int i, input logic [31:0] a, input logic w, input logic [3:0] l);
        REQ_ADDR[32*i +: 32] = a;
        REQ_WRDN[i]          = w;
        REQ_LEN[4*i +: 4]    = l;
    endtask

    task automatic wait_request(output logic ok);
        ok = 1'b0;
        for (int i = 0; i < 30; i++) begin
            step();
            if (REQUEST === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_done(output logic ok, output int nreq);
        ok   = 1'b0;
        nreq = 0;
        for (int i = 0; i < 30; i++) begin
            if (|DONE) begin
                ok = 1'b1;
                break;
            end
            if (REQUEST === 1'b1) nreq++;
            step();
        end
    endtask

    // Called on the REQUEST cycle: address phase, then nvld data phases.
    task automatic attempt(input int gi, input int nvld, output logic [31:0] a,
                           output logic [3:0] c, output int nd,
                           output logic [31:0] cm, output logic ra);
        nd = 0;
        cm = '0;
        step();
        ra       = REQUEST;
        M_ADDR_N = 1'b0;
        #1;
        a = M_ADDR;
        c = M_CBE;
        step();
        M_ADDR_N = 1'b1;
        M_DATA   = 1'b1;
        for (int i = 0; i < nvld; i++) begin
            M_DATA_VLD = 1'b1;
            #1;
            if (DVLD === 4'(1 << gi)) nd++;
            cm[i] = COMPLETE;
            step();
        end
        if (nvld == 0) step();
        M_DATA     = 1'b0;
        M_DATA_VLD = 1'b0;
    endtask

    task automatic test_reset();
        RST_N = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        n_total++;
        if ({GNT, REQUEST, COMPLETE, M_WRDN, M_CBE, M_ADDR, DONE, ERR} !== '0) begin
            n_bad++;
            $display("FAIL reset_outputs: got GNT=%b REQUEST=%b COMPLETE=%b M_WRDN=%b M_CBE=%h M_ADDR=%h DONE=%b ERR=%b required all 0",
                     GNT, REQUEST, COMPLETE, M_WRDN, M_CBE, M_ADDR, DONE, ERR);
        end
        RST_N = 1'b1;
        step();
    endtask

    task automatic test_round_robin();
        logic ok, ra;
        logic [31:0] a, cm;
        logic [3:0] c;
        int nd, nr, ex;
        for (int i = 0; i < 4; i++) set_req(i, 32'h4000_0000 + 32'(i * 256), 1'b0, 4'd1);
        REQ = 4'hF;
        for (int k = 0; k < 5; k++) begin
            ex = k % 4;
            wait_request(ok);
            n_total += 2;
            if (!ok) begin n_bad++; $display("FAIL rr_request: got timeout required REQUEST"); end
            if (GNT !== 4'(1 << ex)) begin
                n_bad++;
                $display("FAIL rr_grant: got GNT=%b required %b", GNT, 4'(1 << ex));
            end
            sb.push_back('{ex, 1'b0});
            attempt(ex, 1, a, c, nd, cm, ra);
            n_total += 2;
            if (a !== 32'h4000_0000 + 32'(ex * 256)) begin
                n_bad++;
                $display("FAIL rr_addr: got %h required %h", a, 32'h4000_0000 + 32'(ex * 256));
            end
            if (cm[0] !== 1'b1) begin n_bad++; $display("FAIL rr_complete: got %b required 1", cm[0]); end
            wait_done(ok, nr);
            n_total++;
            if (!ok) begin n_bad++; $display("FAIL rr_done: got timeout required DONE"); end
            if (k == 4) REQ = '0;
        end
    endtask

    task automatic test_single_write();
        logic ok, ra;
        logic [31:0] a, cm;
        logic [3:0] c;
        int nd, nr;
        set_req(1, 32'h1000_0000, 1'b1, 4'd4);
        step(); step();
        REQ = 4'b0010;
        step();
        n_total++;
        if (GNT !== 4'b0000) begin n_bad++; $display("FAIL wr_gnt_early: got %b required 0000", GNT); end
        step();
        n_total++;
        if ({GNT, REQUEST} !== 5'b0010_1) begin
            n_bad++;
            $display("FAIL wr_gnt_latency: got GNT=%b REQUEST=%b required 0010 1", GNT, REQUEST);
        end
        REQ = '0;
        sb.push_back('{1, 1'b0});
        attempt(1, 4, a, c, nd, cm, ra);
        n_total += 6;
        if (a !== 32'h1000_0000) begin n_bad++; $display("FAIL wr_addr: got %h required 10000000", a); end
        if (c !== 4'h7) begin n_bad++; $display("FAIL wr_cbe: got %h required 7", c); end
        if (nd !== 4) begin n_bad++; $display("FAIL wr_dvld: got %0d required 4", nd); end
        if (cm[3:0] !== 4'b1100) begin n_bad++; $display("FAIL wr_complete: got %b required 1100", cm[3:0]); end
        if (ra !== 1'b0) begin n_bad++; $display("FAIL wr_request_len: got %b required 0", ra); end
        if (M_WRDN !== 1'b1) begin n_bad++; $display("FAIL wr_wrdn: got %b required 1", M_WRDN); end
        wait_done(ok, nr);
        n_total++;
        if (!ok) begin n_bad++; $display("FAIL wr_done: got timeout required DONE"); end
    endtask

    task automatic test_len16_read();
        logic ok, ra;
        logic [31:0] a, cm;
        logic [3:0] c;
        int nd, nr;
        set_req(2, 32'h2000_0100, 1'b0, 4'd0);
        REQ = 4'b0100;
        wait_request(ok);
        REQ = '0;
        sb.push_back('{2, 1'b0});
        attempt(2, 16, a, c, nd, cm, ra);
        n_total += 4;
        if (a !== 32'h2000_0100) begin n_bad++; $display("FAIL rd16_addr: got %h required 20000100", a); end
        if (c !== 4'h6) begin n_bad++; $display("FAIL rd16_cbe: got %h required 6", c); end
        if (nd !== 16) begin n_bad++; $display("FAIL rd16_dvld: got %0d required 16", nd); end
        if (cm[15:0] !== 16'hC000) begin n_bad++; $display("FAIL rd16_complete: got %h required c000", cm[15:0]); end
        wait_done(ok, nr);
        n_total++;
        if (!ok) begin n_bad++; $display("FAIL rd16_done: got timeout required DONE"); end
    endtask

    task automatic test_overrun();
        logic ok, ra;
        logic [31:0] a, cm;
        logic [3:0] c;
        int nd, nr;
        set_req(3, 32'h7000_0000, 1'b1, 4'd1);
        REQ = 4'b1000;
        wait_request(ok);
        REQ = '0;
        sb.push_back('{3, 1'b1});
        attempt(3, 2, a, c, nd, cm, ra);
        n_total++;
        if (nd !== 2) begin n_bad++; $display("FAIL over_dvld: got %0d required 2", nd); end
        wait_done(ok, nr);
        n_total++;
        if (!ok) begin n_bad++; $display("FAIL over_done: got timeout required DONE"); end
    endtask

    task automatic test_disconnect();
        logic ok, ra;
        logic [31:0] a, cm;
        logic [3:0] c;
        int nd, nr;
        set_req(0, 32'h3000_0000, 1'b0, 4'd8);
        REQ = 4'b0001;
        wait_request(ok);
        REQ = '0;
`ifdef PCI_INIT_ARB_RETRY_EN
        sb.push_back('{0, 1'b0});
`else
        sb.push_back('{0, 1'b1});
`endif
        attempt(0, 3, a, c, nd, cm, ra);
        n_total += 3;
        if (a !== 32'h3000_0000) begin n_bad++; $display("FAIL disc_addr: got %h required 30000000", a); end
        if (nd !== 3) begin n_bad++; $display("FAIL disc_dvld: got %0d required 3", nd); end
        if (cm[2:0] !== 3'b000) begin n_bad++; $display("FAIL disc_complete: got %b required 000", cm[2:0]); end
`ifdef PCI_INIT_ARB_RETRY_EN
        wait_request(ok);
        n_total += 2;
        if (!ok) begin n_bad++; $display("FAIL disc_rerequest: got timeout required REQUEST"); end
        if (GNT !== 4'b0001) begin n_bad++; $display("FAIL disc_gnt: got %b required 0001", GNT); end
        attempt(0, 5, a, c, nd, cm, ra);
        n_total += 3;
        if (a !== 32'h3000_000C) begin n_bad++; $display("FAIL disc_readdr: got %h required 3000000c", a); end
        if (nd !== 5) begin n_bad++; $display("FAIL disc_dvld2: got %0d required 5", nd); end
        if (cm[4:0] !== 5'b11000) begin n_bad++; $display("FAIL disc_complete2: got %b required 11000", cm[4:0]); end
`endif
        wait_done(ok, nr);
        n_total++;
        if (!ok) begin n_bad++; $display("FAIL disc_done: got timeout required DONE"); end
    endtask

    task automatic test_abort();
        logic ok, ra;
        logic [31:0] a, cm;
        logic [3:0] c;
        int nd, nr, nreq;
        nreq = 0;
        set_req(1, 32'h6000_0000, 1'b1, 4'd8);
        REQ = 4'b0010;
        sb.push_back('{1, 1'b1});
`ifdef PCI_INIT_ARB_RETRY_EN
        for (int r = 0; r < 3; r++) begin
`else
        for (int r = 0; r < 1; r++) begin
`endif
            wait_request(ok);
            n_total++;
            if (!ok) begin n_bad++; $display("FAIL abort_request: got timeout required REQUEST %0d", r); end
            else nreq++;
            REQ = '0;
            attempt(1, 1, a, c, nd, cm, ra);
        end
        wait_done(ok, nr);
        nreq += nr;
        n_total += 2;
        if (!ok) begin n_bad++; $display("FAIL abort_done: got timeout required DONE"); end
`ifdef PCI_INIT_ARB_RETRY_EN
        if (nreq !== 3) begin n_bad++; $display("FAIL abort_count: got %0d required 3", nreq); end
`else
        if (nreq !== 1) begin n_bad++; $display("FAIL abort_count: got %0d required 1", nreq); end
`endif
    endtask

    task automatic test_timeout();
        logic ok, ra;
        logic [31:0] a, cm;
        logic [3:0] c;
        int nd, nr;
        set_req(3, 32'h5000_0000, 1'b1, 4'd8);
        REQ = 4'b1000;
        wait_request(ok);
        REQ = '0;
`ifdef PCI_INIT_ARB_RETRY_EN
        sb.push_back('{3, 1'b0});
`else
        sb.push_back('{3, 1'b1});
`endif
        step();
        M_ADDR_N = 1'b0;
        step();
        M_ADDR_N   = 1'b1;
        M_DATA     = 1'b1;
        M_DATA_VLD = 1'b1;
        step();
        M_DATA_VLD = 1'b0;
        TIME_OUT   = 1'b1;
        #1;
        n_total++;
        if (COMPLETE !== 1'b1) begin n_bad++; $display("FAIL to_complete: got %b required 1", COMPLETE); end
        step();
        TIME_OUT = 1'b0;
        #1;
        n_total++;
        if (COMPLETE !== 1'b1) begin n_bad++; $display("FAIL to_complete_hold: got %b required 1", COMPLETE); end
        step();
        M_DATA = 1'b0;
`ifdef PCI_INIT_ARB_RETRY_EN
        wait_request(ok);
        attempt(3, 7, a, c, nd, cm, ra);
        n_total += 2;
        if (a !== 32'h5000_0004) begin n_bad++; $display("FAIL to_readdr: got %h required 50000004", a); end
        if (cm[6:0] !== 7'b1100000) begin n_bad++; $display("FAIL to_complete2: got %b required 1100000", cm[6:0]); end
`endif
        wait_done(ok, nr);
        n_total++;
        if (!ok) begin n_bad++; $display("FAIL to_done: got timeout required DONE"); end
    endtask

    task automatic test_reset_mid();
        logic ok, ra;
        logic [31:0] a, cm;
        logic [3:0] c;
        int nd, nr;
        for (int i = 0; i < 4; i++) set_req(i, 32'h8000_0000 + 32'(i * 16), 1'b0, 4'd1);
        set_req(2, 32'h9000_0000, 1'b0, 4'd2);
        REQ = 4'b0100;
        wait_request(ok);
        REQ = '0;
        step();
        M_ADDR_N = 1'b0;
        M_DATA   = 1'b1;
        #1;
        n_total++;
        if ({GNT, COMPLETE, M_CBE} !== {4'b0100, 1'b1, 4'h6}) begin
            n_bad++;
            $display("FAIL rstmid_pre: got GNT=%b COMPLETE=%b M_CBE=%h required 0100 1 6", GNT, COMPLETE, M_CBE);
        end
        #1;
        RST_N = 1'b0;
        #1;
        n_total++;
        if ({GNT, REQUEST, COMPLETE, M_CBE, M_ADDR} !== '0) begin
            n_bad++;
            $display("FAIL rstmid_outputs: got GNT=%b REQUEST=%b COMPLETE=%b M_CBE=%h M_ADDR=%h required all 0",
                     GNT, REQUEST, COMPLETE, M_CBE, M_ADDR);
        end
        M_ADDR_N = 1'b1;
        M_DATA   = 1'b0;
        step(); step();
        RST_N = 1'b1;
        step();
        REQ = 4'hF;
        wait_request(ok);
        n_total++;
        if (GNT !== 4'b0001) begin n_bad++; $display("FAIL rstmid_first: got GNT=%b required 0001", GNT); end
        REQ = '0;
        sb.push_back('{0, 1'b0});
        attempt(0, 1, a, c, nd, cm, ra);
        wait_done(ok, nr);
        n_total++;
        if (!ok) begin n_bad++; $display("FAIL rstmid_done: got timeout required DONE"); end
        step(); step();
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_single_write();
        test_len16_read();
        test_overrun();
        test_disconnect();
        test_abort();
        test_timeout();
        test_reset_mid();
        n_total++;
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL sb_drain: got %0d pending completions required 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout required end of test");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
